// File: rtl/i3c_pkg.sv
// rtl/i3c_pkg.sv - shared I3C types for the SDR transmit sequencer
package i3c_pkg;

  typedef enum logic [1:0] {
    SeqIdle     = 2'd0,
    SeqWaitIdle = 2'd1,
    SeqSendByte = 2'd2,
    SeqSendTbit = 2'd3
  } sdr_seq_state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrUnderrun = 2'd1,
    ErrAbort    = 2'd2,
    ErrReqError = 2'd3
  } sdr_seq_err_e;

  localparam logic TbitParity = 1'b0;
  localparam logic TbitEod    = 1'b1;

  // Odd parity for controller writes; end-of-data marker (1 = more follows) for target reads.
  function automatic logic calc_tbit(input logic mode, input logic [7:0] data, input logic last);
    return (mode == TbitEod) ? ~last : ~^data;
  endfunction

endpackage

// File: rtl/sdr_tx_sequencer.sv
// rtl/sdr_tx_sequencer.sv - sequences one SDR data frame as alternating byte / T-bit requests
module sdr_tx_sequencer
  import i3c_pkg::*;
#(
  parameter int CntW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            tbit_mode_i,
  input  logic            data_valid_i,
  input  logic [7:0]      data_i,
  input  logic            data_last_i,
  output logic            data_ready_o,
  output logic            req_byte_o,
  output logic            req_bit_o,
  output logic [7:0]      req_value_o,
  input  logic            bus_tx_done_i,
  input  logic            bus_tx_idle_i,
  input  logic            req_error_i,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic [CntW-1:0] byte_cnt_o
);

  sdr_seq_state_e state_q, state_d;
  logic           last_q, last_d;
  logic           tbit_q, tbit_d;
  logic           ready_d, req_byte_d, req_bit_d, busy_d, frame_done_d, err_d;
  logic [7:0]     value_d;
  sdr_seq_err_e   err_code_d;
  logic [CntW-1:0] cnt_d;
  logic           take_byte, finish;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SeqIdle;
      last_q       <= 1'b0;
      tbit_q       <= 1'b0;
      data_ready_o <= 1'b0;
      req_byte_o   <= 1'b0;
      req_bit_o    <= 1'b0;
      req_value_o  <= 8'h00;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= 2'd0;
      byte_cnt_o   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      tbit_q       <= tbit_d;
      data_ready_o <= ready_d;
      req_byte_o   <= req_byte_d;
      req_bit_o    <= req_bit_d;
      req_value_o  <= value_d;
      busy_o       <= busy_d;
      frame_done_o <= frame_done_d;
      err_o        <= err_d;
      err_code_o   <= err_code_d;
      byte_cnt_o   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    tbit_d       = tbit_q;
    ready_d      = 1'b0;
    req_byte_d   = req_byte_o;
    req_bit_d    = req_bit_o;
    value_d      = req_value_o;
    busy_d       = busy_o;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    err_code_d   = ErrNone;
    cnt_d        = byte_cnt_o;
    take_byte    = 1'b0;
    finish       = 1'b0;

    if (state_q == SeqIdle) begin
      if (start_i) begin
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SeqWaitIdle;
      end
    end else if (abort_i || req_error_i) begin
      // Abort outranks a transmit error, and both outrank done handling.
      finish     = 1'b1;
      err_d      = 1'b1;
      err_code_d = abort_i ? ErrAbort : ErrReqError;
    end else begin
      case (state_q)
        SeqWaitIdle: begin
          if (bus_tx_idle_i && data_valid_i) take_byte = 1'b1;
        end
        SeqSendByte: begin
          if (bus_tx_done_i) begin
            req_byte_d = 1'b0;
            req_bit_d  = 1'b1;
            value_d    = {7'b0, tbit_q};
            state_d    = SeqSendTbit;
          end
        end
        SeqSendTbit: begin
          if (bus_tx_done_i) begin
            cnt_d = byte_cnt_o + CntW'(1);
            if (last_q) begin
              finish       = 1'b1;
              frame_done_d = 1'b1;
            end else if (data_valid_i) begin
              take_byte = 1'b1;
            end else begin
              finish     = 1'b1;
              err_d      = 1'b1;
              err_code_d = ErrUnderrun;
            end
          end
        end
        default: state_d = SeqIdle;
      endcase
    end

    if (take_byte) begin
      ready_d    = 1'b1;
      last_d     = data_last_i;
      tbit_d     = calc_tbit(tbit_mode_i, data_i, data_last_i);
      req_byte_d = 1'b1;
      req_bit_d  = 1'b0;
      value_d    = data_i;
      state_d    = SeqSendByte;
    end

    if (finish) begin
      req_byte_d = 1'b0;
      req_bit_d  = 1'b0;
      value_d    = 8'h00;
      busy_d     = 1'b0;
      state_d    = SeqIdle;
    end
  end

endmodule

// File: tb/tb_sdr_tx_sequencer.sv
// tb/tb_sdr_tx_sequencer.sv - scoreboard bench for sdr_tx_sequencer with a bus_tx_flow stand-in
module tb_sdr_tx_sequencer;
  import i3c_pkg::*;

  localparam int CNTW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start_i = 0, abort_i = 0, tbit_mode_i = 0;
  logic data_valid_i = 0, data_last_i = 0;
  logic [7:0] data_i = 8'h00;
  logic bus_tx_done_i = 0, bus_tx_idle_i = 1, req_error_i = 0;
  logic data_ready_o, req_byte_o, req_bit_o, busy_o, frame_done_o, err_o;
  logic [7:0] req_value_o;
  logic [1:0] err_code_o;
  logic [CNTW-1:0] byte_cnt_o;

  always #5 clk = ~clk;

  sdr_tx_sequencer #(.CntW(CNTW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .tbit_mode_i(tbit_mode_i), .data_valid_i(data_valid_i), .data_i(data_i),
    .data_last_i(data_last_i), .data_ready_o(data_ready_o), .req_byte_o(req_byte_o),
    .req_bit_o(req_bit_o), .req_value_o(req_value_o), .bus_tx_done_i(bus_tx_done_i),
    .bus_tx_idle_i(bus_tx_idle_i), .req_error_i(req_error_i), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_o(err_o), .err_code_o(err_code_o),
    .byte_cnt_o(byte_cnt_o)
  );

  typedef struct {logic [1:0] kind; logic [7:0] value;} txn_t;
  typedef struct {logic is_err; logic [1:0] code; logic [CNTW-1:0] cnt;} end_t;
  typedef struct {logic [7:0] d; logic last;} sbyte_t;

  txn_t   exp_q[$];
  end_t   end_q[$];
  sbyte_t stream_q[$];

  int n_checks = 0, n_pass = 0, end_seen = 0, ready_cnt = 0;
  int lat_max = 2, lat = 1, bus_cnt = 0;
  bit valid_en = 0, idle_rand = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each byte becomes a byte request then its T-bit; frame ends with done or underrun.
  task automatic build(input logic [7:0] bq[$], input logic mode, input bit has_last, input bit push_end);
    for (int i = 0; i < bq.size(); i++) begin
      logic lst;
      logic t;
      lst = has_last && (i == bq.size() - 1);
      t = mode ? !lst : (($countones(bq[i]) % 2) == 0);
      exp_q.push_back('{2'b10, bq[i]});
      exp_q.push_back('{2'b01, {7'b0, t}});
      stream_q.push_back('{bq[i], lst});
    end
    if (push_end)
      end_q.push_back('{!has_last, has_last ? 2'd0 : 2'd1, CNTW'(bq.size() % (1 << CNTW))});
  endtask

  // bus_tx_flow stand-in and stream source
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus_tx_done_i = 0;
        bus_cnt = 0;
      end else if (bus_tx_done_i) begin
        bus_tx_done_i = 0;
        bus_cnt = 0;
      end else if (req_byte_o || req_bit_o) begin
        bus_cnt++;
        if (lat_max != 0 && bus_cnt >= lat) begin
          bus_tx_done_i = 1;
          lat = $urandom_range(1, lat_max);
        end
      end else begin
        bus_cnt = 0;
      end
      if (rst_n && data_ready_o) begin
        ready_cnt++;
        if (stream_q.size() > 0) void'(stream_q.pop_front());
      end
      data_valid_i = valid_en && (stream_q.size() > 0);
      data_i       = (stream_q.size() > 0) ? stream_q[0].d : 8'h00;
      data_last_i  = (stream_q.size() > 0) ? stream_q[0].last : 1'b0;
      bus_tx_idle_i = idle_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a request or ends a frame
  bit gap_pending = 0, gap_was_byte = 0, gap_more = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_tx_done_i && (req_byte_o || req_bit_o)) begin
          if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
          else begin
            txn_t e;
            e = exp_q.pop_front();
            chk("req_kind", {req_byte_o, req_bit_o}, e.kind);
            chk("req_value", req_value_o, e.value);
          end
          gap_pending  = 1;
          gap_was_byte = req_byte_o;
          gap_more     = exp_q.size() != 0;
        end else if (gap_pending) begin
          gap_pending = 0;
          if (gap_was_byte) chk("nogap_tbit", req_bit_o, 1);
          else if (gap_more) chk("nogap_byte", req_byte_o, 1);
        end
        if (frame_done_o || err_o) begin
          end_seen++;
          if (end_q.size() == 0) chk("unexpected_end", 1, 0);
          else begin
            end_t x;
            x = end_q.pop_front();
            chk("end_kind", {frame_done_o, err_o}, {!x.is_err, x.is_err});
            chk("err_code", err_code_o, x.code);
            chk("end_byte_cnt", byte_cnt_o, x.cnt);
            chk("end_busy", busy_o, 0);
            chk("end_reqs", {req_byte_o, req_bit_o}, 0);
          end
        end
      end else begin
        gap_pending = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2; start_i = 1;
    @(posedge clk); #2; start_i = 0;
  endtask

  task automatic run_frame(input logic [7:0] bq[$], input logic mode, input bit has_last, input bit noise);
    int rc0, es0;
    tbit_mode_i = mode;
    build(bq, mode, has_last, 1);
    rc0 = ready_cnt;
    es0 = end_seen;
    pulse_start();
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #2 valid_en = 1;
    for (int c = 0; c < 20000 && end_seen == es0; c++) begin
      @(posedge clk); #2;
      start_i = noise && busy_o && ($urandom_range(0, 7) == 0);
    end
    start_i = 0;
    if (end_seen == es0) chk("frame_timeout", 0, 1);
    valid_en = 0;
    chk("ready_pulses", ready_cnt - rc0, bq.size());
    chk("exp_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #2 chk("cnt_hold", byte_cnt_o, CNTW'(bq.size() % (1 << CNTW)));
  endtask

  task automatic wait_for(input int which, output bit ok);
    ok = 0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(posedge clk); #2;
      case (which)
        0: ok = req_byte_o;
        1: ok = req_bit_o;
        default: ok = req_byte_o && (byte_cnt_o == 1);
      endcase
    end
  endtask

  logic [7:0] bq[$];
  bit ok;

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 chk("reset_outputs", {data_ready_o, req_byte_o, req_bit_o, req_value_o, busy_o,
                             frame_done_o, err_o, err_code_o, byte_cnt_o}, 0);
    rst_n = 1;
    @(posedge clk);
    #2 chk("post_reset_idle", {busy_o, req_byte_o, req_bit_o, byte_cnt_o}, 0);

    bq = {8'hA5, 8'h01};
    run_frame(bq, TbitParity, 1, 0);
    bq = {8'h00, 8'hFF, 8'h3C};
    run_frame(bq, TbitEod, 1, 0);
    bq = {8'h96};
    run_frame(bq, TbitParity, 0, 0);

    // Abort in Idle must be silent
    @(posedge clk); #2 abort_i = 1;
    repeat (2) @(posedge clk);
    #2 chk("idle_abort_no_err", {err_o, busy_o}, 0);
    abort_i = 0;

    // Abort mid second byte
    lat_max = 2;
    tbit_mode_i = TbitParity;
    bq = {8'h5A, 8'h3C};
    build(bq, TbitParity, 1, 0);
    end_q.push_back('{1'b1, 2'd2, CNTW'(1)});
    pulse_start();
    valid_en = 1;
    wait_for(2, ok);
    lat_max = 0;
    chk("abort_reached", ok, 1);
    repeat (4) @(posedge clk);
    #2 abort_i = 1;
    @(posedge clk); #2 abort_i = 0;
    chk("abort_reqs", {req_byte_o, req_bit_o, busy_o, data_ready_o}, 0);
    chk("abort_cnt", byte_cnt_o, 1);
    exp_q.delete(); stream_q.delete(); valid_en = 0;
    @(posedge clk); #2 chk("abort_end_seen", end_q.size(), 0);

    // Transmit error during T-bit, with a start pulse that must be ignored
    lat_max = 1;
    bq = {8'hC3, 8'h11};
    build(bq, TbitParity, 1, 0);
    end_q.push_back('{1'b1, 2'd3, CNTW'(0)});
    pulse_start();
    valid_en = 1;
    wait_for(1, ok);
    lat_max = 0;
    chk("reqerr_reached", ok, 1);
    req_error_i = 1; start_i = 1;
    @(posedge clk); #2 req_error_i = 0; start_i = 0;
    chk("reqerr_reqs", {req_byte_o, req_bit_o, busy_o}, 0);
    exp_q.delete(); stream_q.delete(); valid_en = 0;
    repeat (2) @(posedge clk);
    #2 chk("start_ignored", busy_o, 0);
    chk("reqerr_end_seen", end_q.size(), 0);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      int n;
      n = $urandom_range(1, 6);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      lat_max = $urandom_range(1, 4);
      idle_rand = 1;
      run_frame(bq, 1'($urandom), ($urandom_range(0, 3) != 0), 1);
    end
    idle_rand = 0;

    // Counter wrap: 258 bytes leaves 2
    lat_max = 1;
    bq.delete();
    for (int i = 0; i < 258; i++) bq.push_back(8'($urandom));
    run_frame(bq, TbitEod, 1, 0);

    // Async reset mid-byte
    lat_max = 0;
    bq = {8'h77};
    build(bq, TbitParity, 1, 0);
    pulse_start();
    valid_en = 1;
    wait_for(0, ok);
    chk("rst_reached", ok, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 0;
    #1 chk("async_reset_outputs", {data_ready_o, req_byte_o, req_bit_o, req_value_o, busy_o,
                                   frame_done_o, err_o, err_code_o, byte_cnt_o}, 0);
    exp_q.delete(); stream_q.delete(); end_q.delete(); valid_en = 0;
    @(posedge clk); #2 rst_n = 1;
    lat_max = 2;
    repeat (3) @(posedge clk);
    #2 chk("after_reset_idle", {busy_o, req_byte_o, req_bit_o}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
